// File: rtl/uart_rx_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl_if
// Groups every non-clock/reset signal of uart_rx_fifo_ctrl.
//   UART receiver side : rx_fifo_wen, rx_fifo_wa[8:0], rx_fifo_wd[7:0],
//                        rx_fifo_full, rx_fifo_full_ack
//   RAM port (512x8)   : mem_en, mem_we, mem_addr[8:0], mem_wdata[7:0],
//                        mem_rdata[7:0]
//   Consumer side      : rd_req, rd_valid, rd_data[7:0], rd_err
//   Status / control   : count[9:0], empty, overflow, sw_ack
// modport slave  : the controller itself
// modport master : the environment (UART, RAM, consumer, software)
// -----------------------------------------------------------------------------
interface uart_rx_fifo_ctrl_if;
    logic       rx_fifo_wen;
    logic [8:0] rx_fifo_wa;
    logic [7:0] rx_fifo_wd;
    logic       rx_fifo_full;
    logic       rx_fifo_full_ack;
    logic       mem_en;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_err;
    logic [9:0] count;
    logic       empty;
    logic       overflow;
    logic       sw_ack;

    modport slave (
        input  rx_fifo_wen, rx_fifo_wa, rx_fifo_wd, rx_fifo_full,
        input  mem_rdata, rd_req, sw_ack,
        output rx_fifo_full_ack, mem_en, mem_we, mem_addr, mem_wdata,
        output rd_valid, rd_data, rd_err, count, empty, overflow
    );

    modport master (
        output rx_fifo_wen, rx_fifo_wa, rx_fifo_wd, rx_fifo_full,
        output mem_rdata, rd_req, sw_ack,
        input  rx_fifo_full_ack, mem_en, mem_we, mem_addr, mem_wdata,
        input  rd_valid, rd_data, rd_err, count, empty, overflow
    );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// Turns a UART receive buffer held in a single-port 512x8 RAM into a FIFO
// for a byte consumer. The UART writes by address; this block reads back in
// order, arbitrates the shared RAM port (writes always win), tracks the fill
// level and acknowledges the UART's full flag once everything has been read.
//
// Ports
//   clk      : system clock, all logic on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : uart_rx_fifo_ctrl_if.slave (UART, RAM, consumer, status)
// Parameter
//   AUTO_ACK : 1 = acknowledge the drained full buffer automatically,
//              0 = wait for sw_ack
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | port free for reads; grants reads, reports empty reads,
//           | detects the drain condition
// READ_WAIT | RAM read in flight; capture mem_rdata, pulse rd_valid
// ACK       | one-cycle rx_fifo_full_ack; rewind rd_ptr, clear overflow
// -----------------------------------------------------------------------------
module uart_rx_fifo_ctrl #(
    parameter bit AUTO_ACK = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_rx_fifo_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        ACK       = 2'd2
    } state_t;

    state_t     state_q,    state_d;
    logic [8:0] rd_ptr_q,   rd_ptr_d;
    logic [9:0] count_q,    count_d;
    logic       pend_q,     pend_d;
    logic [7:0] rd_data_q,  rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       rd_err_q,   rd_err_d;
    logic       overflow_q, overflow_d;
    logic       full_ack_q, full_ack_d;

    logic fifo_full;
    logic wr_acc;
    logic rd_grant;
    logic drain;

    assign fifo_full = (count_q == 10'd512);
    assign wr_acc    = bus.rx_fifo_wen && !fifo_full;

    // Any write strobe (even a dropped one) keeps the port away from reads.
    assign rd_grant  = (state_q == IDLE) && !bus.rx_fifo_wen
                     && (bus.rd_req || pend_q) && (count_q != 10'd0);

    assign drain     = (state_q == IDLE) && bus.rx_fifo_full
                     && (count_q == 10'd0) && !pend_q
                     && (AUTO_ACK || bus.sw_ack);

    // RAM port: combinational, gated off entirely while in reset.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = rd_ptr_q;
        bus.mem_wdata = bus.rx_fifo_wd;
        if (reset_n) begin
            if (bus.rx_fifo_wen) begin
                bus.mem_addr = bus.rx_fifo_wa;
                bus.mem_en   = wr_acc;
                bus.mem_we   = wr_acc;
            end else if (rd_grant) begin
                bus.mem_en   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pend_d     = pend_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        overflow_d = overflow_q;
        full_ack_d = 1'b0;

        if (wr_acc) begin
            count_d = count_q + 10'd1;
        end
        if (bus.rx_fifo_wen && fifo_full) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rd_grant) begin
                    rd_ptr_d = rd_ptr_q + 9'd1;
                    count_d  = count_q - 10'd1;
                    pend_d   = 1'b0;
                    state_d  = READ_WAIT;
                end else if (bus.rd_req) begin
                    // Empty with nothing queued: reject. Otherwise the read is
                    // blocked by a write (or merges with one already queued).
                    if ((count_q == 10'd0) && !pend_q) begin
                        rd_err_d = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
                // drain needs count==0, so it never coincides with a grant
                if (drain) begin
                    state_d    = ACK;
                    full_ack_d = 1'b1;
                end
            end
            READ_WAIT: begin
                rd_data_d  = bus.mem_rdata;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
                if (bus.rd_req) begin
                    pend_d = 1'b1;
                end
            end
            ACK: begin
                rd_ptr_d   = 9'd0;
                overflow_d = 1'b0;
                state_d    = IDLE;
                if (bus.rd_req) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= 9'd0;
            count_q    <= 10'd0;
            pend_q     <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            overflow_q <= 1'b0;
            full_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            overflow_q <= overflow_d;
            full_ack_q <= full_ack_d;
        end
    end

    assign bus.rx_fifo_full_ack = full_ack_q;
    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_data          = rd_data_q;
    assign bus.rd_err           = rd_err_q;
    assign bus.count            = count_q;
    assign bus.empty            = (count_q == 10'd0);
    assign bus.overflow         = overflow_q;

endmodule
